// File: rtl/sub_reg_pkg.sv
// Shared types and the subtract helper for the registered subtractor pipeline.
// Optional macro SUB_REG_SAT_EN clamps the difference to zero whenever a borrow occurs.
package sub_reg_pkg;

    localparam int SUB_W     = 2;
    localparam int SUB_MAX_W = 32;

    typedef struct packed {
        logic             borrow;
        logic [SUB_W-1:0] diff;
    } sub_res_t;

    typedef struct packed {
        logic                 borrow;
        logic [SUB_MAX_W-1:0] diff;
    } sub_wide_t;

    // Operands arrive zero-extended to SUB_MAX_W.
    // The extra top bit of the subtract is the borrow.
    function automatic sub_wide_t sub_diff(input logic [SUB_MAX_W-1:0] a,
                                           input logic [SUB_MAX_W-1:0] b);
        logic [SUB_MAX_W:0] wide;
        sub_wide_t          res;
        wide       = {1'b0, a} - {1'b0, b};
        res.borrow = wide[SUB_MAX_W];
        res.diff   = wide[SUB_MAX_W-1:0];
`ifdef SUB_REG_SAT_EN
        if (res.borrow) res.diff = '0;
`else
        res.diff = res.diff;
`endif
        return res;
    endfunction

endpackage

// File: rtl/sub_reg_pipe_if.sv
// Operand/result handshake bundle for sub_reg_pipe; master drives operands and result-ready.
interface sub_reg_pipe_if #(parameter int WIDTH = 2);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow
    );

endinterface

// File: rtl/sub_reg_pipe_stage.sv
// One valid/ready register slice; the held word only changes when a new item is accepted.
module pipe_stage #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic          valid_q;
    logic [DW-1:0] data_q;

    // Ready while empty or while the current item leaves downstream this cycle.
    assign in_ready  = ~valid_q | out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_ready) begin
            valid_q <= in_valid;
            if (in_valid) data_q <= in_data;
        end
    end

endmodule

// File: rtl/sub_reg_pipe.sv
// Two-stage registered a-b with valid/ready flow control and a saturating borrow counter.
// Define SUB_REG_SAT_EN to clamp the difference to zero on borrow (see sub_reg_pkg).
module sub_reg_pipe
    import sub_reg_pkg::*;
#(
    parameter int WIDTH = SUB_W,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    sub_reg_pipe_if.slave    bus,
    input  logic             brw_clr,
    output logic [CNT_W-1:0] brw_cnt
);

    logic               s1_valid;
    logic               s2_ready;
    logic [2*WIDTH-1:0] s1_data;
    logic [WIDTH:0]     s2_data;
    sub_wide_t          res;
    logic               unused_hi;
    logic               brw_fire;

    pipe_stage #(.DW(2*WIDTH)) u_s1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   ({bus.a, bus.b}),
        .out_valid (s1_valid),
        .out_ready (s2_ready),
        .out_data  (s1_data)
    );

    // Subtract sits between the slices so S2 registers the finished result.
    assign res       = sub_diff(SUB_MAX_W'(s1_data[2*WIDTH-1:WIDTH]),
                                SUB_MAX_W'(s1_data[WIDTH-1:0]));
    assign unused_hi = &{1'b0, res.diff[SUB_MAX_W-1:WIDTH]};

    pipe_stage #(.DW(WIDTH+1)) u_s2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .in_ready  (s2_ready),
        .in_data   ({res.borrow, res.diff[WIDTH-1:0]}),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (s2_data)
    );

    assign bus.diff   = s2_data[WIDTH-1:0];
    assign bus.borrow = s2_data[WIDTH];
    assign brw_fire   = bus.out_valid & bus.out_ready & bus.borrow;

    // Clear beats a coincident increment; the count sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            brw_cnt <= '0;
        end else if (brw_clr) begin
            brw_cnt <= '0;
        end else if (brw_fire && (brw_cnt != {CNT_W{1'b1}})) begin
            brw_cnt <= brw_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sub_reg_pipe.sv
// Self-checking bench for sub_reg_pipe: directed scenarios plus a randomized scoreboard run.
module tb_sub_reg_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       brw_clr;
    logic       brw_clr_c;
    logic [7:0] brw_cnt;
    logic [1:0] brw_cnt_c;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;
    logic [3:0] pend[$];

    always #5 clk = ~clk;

    sub_reg_pipe_if #(.WIDTH(2)) bus ();
    sub_reg_pipe_if #(.WIDTH(2)) bus_c ();

    sub_reg_pipe #(.WIDTH(2), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave), .brw_clr(brw_clr), .brw_cnt(brw_cnt)
    );

    sub_reg_pipe #(.WIDTH(2), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .bus(bus_c.slave), .brw_clr(brw_clr_c), .brw_cnt(brw_cnt_c)
    );

    // Reference: difference in plain integer arithmetic
    function automatic int exp_diff(input int a, input int b);
        int d;
        d = (a - b + 4) % 4;
`ifdef SUB_REG_SAT_EN
        if (a < b) d = 0;
`endif
        return d;
    endfunction

    function automatic int exp_borrow(input int a, input int b);
        return (a < b) ? 1 : 0;
    endfunction

    function automatic int sat_inc(input int c, input int maxv);
        return (c >= maxv) ? maxv : c + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit iv, input int av, input int bv, input bit ordy, input bit clr);
        bus.in_valid  = iv;
        bus.a         = av[1:0];
        bus.b         = bv[1:0];
        bus.out_ready = ordy;
        brw_clr       = clr;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        #2;
        checks += 5;
        if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        if (bus.diff !== 2'd0) begin errors++; $display("[TB] FAIL reset_diff: got %0d expected 0", bus.diff); end
        if (bus.borrow !== 1'b0) begin errors++; $display("[TB] FAIL reset_borrow: got %b expected 0", bus.borrow); end
        if (brw_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_brw_cnt: got %0d expected 0", brw_cnt); end
        if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_latency();
        drive(1, 3, 1, 1, 0);
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL lat_in_ready: got %b expected 1", bus.in_ready); end
        tick();
        drive(0, 0, 0, 1, 0);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL lat_early_valid: got %b expected 0", bus.out_valid); end
        tick();
        checks += 3;
        if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL lat_out_valid: got %b expected 1", bus.out_valid); end
        if (int'(bus.diff) !== exp_diff(3, 1)) begin errors++; $display("[TB] FAIL lat_diff: got %0d expected %0d", bus.diff, exp_diff(3, 1)); end
        if (bus.borrow !== 1'b0) begin errors++; $display("[TB] FAIL lat_borrow: got %b expected 0", bus.borrow); end
        tick();
    endtask

    task automatic test_borrow();
        drive(1, 1, 2, 1, 0);
        tick();
        drive(0, 0, 0, 1, 0);
        tick();
        checks += 3;
        if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL brw_out_valid: got %b expected 1", bus.out_valid); end
        if (int'(bus.diff) !== exp_diff(1, 2)) begin errors++; $display("[TB] FAIL brw_diff: got %0d expected %0d", bus.diff, exp_diff(1, 2)); end
        if (bus.borrow !== 1'b1) begin errors++; $display("[TB] FAIL brw_borrow: got %b expected 1", bus.borrow); end
        exp_cnt = sat_inc(exp_cnt, 255);
        tick();
        checks++;
        if (int'(brw_cnt) !== exp_cnt) begin errors++; $display("[TB] FAIL brw_cnt_one: got %0d expected %0d", brw_cnt, exp_cnt); end
    endtask

    task automatic test_back_to_back();
        int  ea[3];
        int  eb[3];
        int  idx;
        bit  sent;
        ea = '{3, 2, 0};
        eb = '{0, 1, 3};
        drive(1, 3, 0, 0, 0);
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_accept0: got %b expected 1", bus.in_ready); end
        tick();
        drive(1, 2, 1, 0, 0);
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_accept1: got %b expected 1", bus.in_ready); end
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 3, 0, 0);
            checks += 2;
            if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_stall_ready: got %b expected 0", bus.in_ready); end
            if (bus.out_valid !== 1'b1 || int'(bus.diff) !== exp_diff(3, 0)) begin
                errors++;
                $display("[TB] FAIL b2b_hold: got valid=%b diff=%0d expected valid=1 diff=%0d", bus.out_valid, bus.diff, exp_diff(3, 0));
            end
            tick();
        end
        idx  = 0;
        sent = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            drive(!sent, 0, 3, 1, 0);
            if (!sent && bus.in_ready) sent = 1;
            if (bus.out_valid) begin
                checks++;
                if (idx >= 3) begin
                    errors++;
                    $display("[TB] FAIL b2b_extra: got diff=%0d expected no output", bus.diff);
                end else begin
                    if (int'(bus.diff) !== exp_diff(ea[idx], eb[idx]) || int'(bus.borrow) !== exp_borrow(ea[idx], eb[idx])) begin
                        errors++;
                        $display("[TB] FAIL b2b_order%0d: got diff=%0d borrow=%b expected diff=%0d borrow=%0d",
                                 idx, bus.diff, bus.borrow, exp_diff(ea[idx], eb[idx]), exp_borrow(ea[idx], eb[idx]));
                    end
                    if (exp_borrow(ea[idx], eb[idx]) == 1) exp_cnt = sat_inc(exp_cnt, 255);
                end
                idx++;
            end
            tick();
        end
        checks += 2;
        if (idx !== 3) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 3", idx); end
        if (int'(brw_cnt) !== exp_cnt) begin errors++; $display("[TB] FAIL b2b_brw_cnt: got %0d expected %0d", brw_cnt, exp_cnt); end
    endtask

    task automatic test_random();
        int        sent;
        int        cyc;
        int        av, bv;
        bit        iv, ordy, clr;
        bit        prev_stall;
        logic [1:0] prev_diff;
        logic       prev_borrow;
        logic [3:0] p;

        drive(0, 0, 0, 0, 1);
        exp_cnt = 0;
        tick();
        checks++;
        if (brw_cnt !== 8'd0) begin errors++; $display("[TB] FAIL rnd_clear: got %0d expected 0", brw_cnt); end

        sent       = 0;
        cyc        = 0;
        prev_stall = 0;
        prev_diff  = '0;
        prev_borrow = 1'b0;
        pend.delete();
        while ((sent < 1000 || pend.size() != 0) && cyc < 6000) begin
            iv   = (sent < 1000) && (($urandom % 4) != 0);
            av   = int'($urandom % 4);
            bv   = int'($urandom % 4);
            ordy = (sent < 1000) ? bit'($urandom % 2) : 1'b1;
            clr  = 1'b0;
            drive(iv, av, bv, ordy, clr);
            if (prev_stall) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.diff !== prev_diff || bus.borrow !== prev_borrow) begin
                    errors++;
                    $display("[TB] FAIL rnd_hold: got valid=%b diff=%0d borrow=%b expected valid=1 diff=%0d borrow=%b",
                             bus.out_valid, bus.diff, bus.borrow, prev_diff, prev_borrow);
                end
            end
            if (bus.out_valid && ordy) begin
                checks++;
                if (pend.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL rnd_spurious: got diff=%0d expected no output", bus.diff);
                end else begin
                    p = pend.pop_front();
                    if (int'(bus.diff) !== exp_diff(int'(p[3:2]), int'(p[1:0])) ||
                        int'(bus.borrow) !== exp_borrow(int'(p[3:2]), int'(p[1:0]))) begin
                        errors++;
                        $display("[TB] FAIL rnd_result: got diff=%0d borrow=%b expected diff=%0d borrow=%0d for a=%0d b=%0d",
                                 bus.diff, bus.borrow, exp_diff(int'(p[3:2]), int'(p[1:0])),
                                 exp_borrow(int'(p[3:2]), int'(p[1:0])), p[3:2], p[1:0]);
                    end
                    if (exp_borrow(int'(p[3:2]), int'(p[1:0])) == 1) exp_cnt = sat_inc(exp_cnt, 255);
                end
            end
            if (iv && bus.in_ready) begin
                pend.push_back({av[1:0], bv[1:0]});
                sent++;
            end
            prev_stall  = bus.out_valid && !ordy;
            prev_diff   = bus.diff;
            prev_borrow = bus.borrow;
            tick();
            cyc++;
            checks++;
            if (int'(brw_cnt) !== exp_cnt) begin
                errors++;
                $display("[TB] FAIL rnd_brw_cnt: got %0d expected %0d at cycle %0d", brw_cnt, exp_cnt, cyc);
            end
        end
        checks++;
        if (sent != 1000 || pend.size() != 0) begin
            errors++;
            $display("[TB] FAIL rnd_drain: got sent=%0d pending=%0d expected sent=1000 pending=0", sent, pend.size());
        end
    endtask

    task automatic test_reset_inflight();
        drive(1, 1, 0, 0, 0);
        tick();
        drive(1, 3, 2, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        checks++;
        if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre_valid: got %b expected 1", bus.out_valid); end
        rst = 1'b1;
        #1;
        checks += 3;
        if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_async_valid: got %b expected 0", bus.out_valid); end
        if (brw_cnt !== 8'd0) begin errors++; $display("[TB] FAIL rst_async_cnt: got %0d expected 0", brw_cnt); end
        if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_async_ready: got %b expected 1", bus.in_ready); end
        @(negedge clk);
        rst = 1'b0;
        pend.delete();
        exp_cnt = 0;
        tick();
        drive(1, 2, 2, 1, 0);
        tick();
        drive(0, 0, 0, 1, 0);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_stale_valid: got %b expected 0", bus.out_valid); end
        tick();
        checks += 2;
        if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL rst_next_valid: got %b expected 1", bus.out_valid); end
        if (int'(bus.diff) !== exp_diff(2, 2) || bus.borrow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_next_diff: got diff=%0d borrow=%b expected diff=%0d borrow=0", bus.diff, bus.borrow, exp_diff(2, 2));
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_no_dup: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_saturate();
        bus_c.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus_c.in_valid = 1'b1;
            bus_c.a        = 2'd1;
            bus_c.b        = 2'd2;
            tick();
        end
        bus_c.in_valid = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (brw_cnt_c !== 2'd3) begin errors++; $display("[TB] FAIL sat_hold: got %0d expected 3", brw_cnt_c); end
        bus_c.in_valid = 1'b1;
        bus_c.a        = 2'd1;
        bus_c.b        = 2'd2;
        tick();
        bus_c.in_valid = 1'b0;
        tick();
        checks++;
        if (bus_c.out_valid !== 1'b1 || bus_c.borrow !== 1'b1 || int'(bus_c.diff) !== exp_diff(1, 2)) begin
            errors++;
            $display("[TB] FAIL sat_clr_pre: got valid=%b borrow=%b diff=%0d expected valid=1 borrow=1 diff=%0d",
                     bus_c.out_valid, bus_c.borrow, bus_c.diff, exp_diff(1, 2));
        end
        brw_clr_c = 1'b1;
        tick();
        brw_clr_c = 1'b0;
        checks++;
        if (brw_cnt_c !== 2'd0) begin errors++; $display("[TB] FAIL sat_clr_wins: got %0d expected 0", brw_cnt_c); end
        bus_c.in_valid = 1'b1;
        bus_c.a        = 2'd0;
        bus_c.b        = 2'd1;
        tick();
        bus_c.in_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (brw_cnt_c !== 2'd1) begin errors++; $display("[TB] FAIL sat_after_clr: got %0d expected 1", brw_cnt_c); end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus_c.in_valid  = 1'b0;
        bus_c.a         = '0;
        bus_c.b         = '0;
        bus_c.out_ready = 1'b0;
        brw_clr_c       = 1'b0;
        test_reset();
        test_latency();
        test_borrow();
        test_back_to_back();
        test_random();
        test_reset_inflight();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
